digest_tx_serializer: RTL and testbench

Downstream stage of the SHA-1 hash block. Captures the 160-bit digest when the hash block signals completion, then streams it byte by byte to the SPART transmitter over a valid/ready handshake. Streaming is MSB-first, either as raw bytes or as uppercase ASCII hex, with an optional CR/LF terminator. Pulses spart_done back to the hash block when the last byte has been accepted.

---
 rtl/digest_tx_pkg.sv | 28 ++
 rtl/nibble_to_ascii.sv | 22 ++
 rtl/digest_tx_serializer.sv | 116 +++++++++++
 tb/tb_digest_tx_serializer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/digest_tx_pkg.sv
// Shared types and constants for the SHA-1 digest transmit path.
// Imported by the serializer top and its ASCII helper.
package digest_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  localparam int DIGEST_BITS = 160;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  function automatic int sym_count(
    input int hex,
    input int crlf
  );
    int n;
    n = (hex != 0) ? 40 : 20;
    if (crlf != 0) n = n + 2;
    return n;
  endfunction

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational nibble to uppercase ASCII hex character.
// 0-9 map to '0'-'9', 10-15 map to 'A'-'F'.
module nibble_to_ascii
  import digest_tx_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] ascii
);

  logic [7:0] nib_w;

  assign nib_w = {4'h0, nib};

  always_comb begin
    if (nib <= 4'd9) begin
      ascii = ASCII_0 + nib_w;
    end else begin
      ascii = ASCII_A + nib_w - 8'd10;
    end
  end

endmodule

// File: rtl/digest_tx_serializer.sv
// Captures a SHA-1 digest and streams it MSB-first to SPART,
// as raw bytes or uppercase ASCII hex, optionally CR/LF-terminated.
module digest_tx_serializer
  import digest_tx_pkg::*;
#(
  parameter int ASCII_HEX   = 1,
  parameter int APPEND_CRLF = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   H_done,
  input  logic [DIGEST_BITS-1:0] hh,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   spart_done,
  output logic                   busy,
  output logic                   overrun
);

  localparam int NSYM = sym_count(ASCII_HEX, APPEND_CRLF);

  localparam logic [5:0] LAST   = 6'(NSYM - 1);
  localparam logic [5:0] CR_IDX = 6'(NSYM - 2);

  state_t state;

  logic [DIGEST_BITS-1:0] sreg;
  logic [DIGEST_BITS-1:0] sreg_nx;
  logic [5:0]             cnt;
  logic [5:0]             cnt_nx;
  logic [7:0]             asc_first;
  logic [7:0]             asc_next;
  logic [7:0]             sym_first;
  logic [7:0]             sym_next;

  // First symbol comes straight from hh so tx_data is ready
  // the cycle after capture; later ones look one shift ahead.
  nibble_to_ascii u_first (
    .nib   (hh[159:156]),
    .ascii (asc_first)
  );

  nibble_to_ascii u_next (
    .nib   (sreg[155:152]),
    .ascii (asc_next)
  );

  always_comb begin
    cnt_nx = cnt + 6'd1;
    if (ASCII_HEX != 0) begin
      sreg_nx   = {sreg[155:0], 4'h0};
      sym_first = asc_first;
      sym_next  = asc_next;
    end else begin
      sreg_nx   = {sreg[151:0], 8'h00};
      sym_first = hh[159:152];
      sym_next  = sreg[151:144];
    end
    if (APPEND_CRLF != 0) begin
      if (cnt_nx == CR_IDX) begin
        sym_next = ASCII_CR;
      end else if (cnt_nx == LAST) begin
        sym_next = ASCII_LF;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      spart_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      spart_done <= 1'b0;
      overrun    <= H_done && (state != IDLE);
      unique case (state)
        IDLE: begin
          if (H_done) begin
            sreg     <= hh;
            cnt      <= '0;
            tx_data  <= sym_first;
            tx_valid <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (cnt == LAST) begin
              tx_valid   <= 1'b0;
              spart_done <= 1'b1;
              state      <= DONE;
            end else begin
              cnt     <= cnt_nx;
              sreg    <= sreg_nx;
              tx_data <= sym_next;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_digest_tx_serializer.sv
// Directed bench for digest_tx_serializer: hex+CRLF and raw
// instances, backpressure, overrun, mid-stream reset, nibble range.
module tb_digest_tx_serializer;

  localparam logic [159:0] ABC =
    160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D;
  localparam logic [159:0] BND =
    160'h0123456789ABCDEF_FEDCBA98_76543210;

  localparam string ABC_S =
    "A9993E364706816ABA3E25717850C26C9CD0D89D";
  localparam string ZERO_S =
    "0000000000000000000000000000000000000000";
  localparam string BND_S =
    "000000000123456789ABCDEFFEDCBA9876543210";

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         h_done = 1'b0;
  logic [159:0] hh = '0;
  logic         tx_ready = 1'b0;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         spart_done;
  logic         busy;
  logic         overrun;

  logic         h_done_r = 1'b0;
  logic [159:0] hh_r = '0;
  logic         tx_ready_r = 1'b0;
  logic [7:0]   tx_data_r;
  logic         tx_valid_r;
  logic         spart_done_r;
  logic         busy_r;
  logic         overrun_r;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  digest_tx_serializer #(
    .ASCII_HEX   (1),
    .APPEND_CRLF (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .H_done     (h_done),
    .hh         (hh),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .spart_done (spart_done),
    .busy       (busy),
    .overrun    (overrun)
  );

  digest_tx_serializer #(
    .ASCII_HEX   (0),
    .APPEND_CRLF (0)
  ) dut_raw (
    .clk        (clk),
    .rst_n      (rst_n),
    .H_done     (h_done_r),
    .hh         (hh_r),
    .tx_data    (tx_data_r),
    .tx_valid   (tx_valid_r),
    .tx_ready   (tx_ready_r),
    .spart_done (spart_done_r),
    .busy       (busy_r),
    .overrun    (overrun_r)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic stream_hex(
    input string        name,
    input logic [159:0] d,
    input string        hex,
    input bit           bp,
    input int           ovr_idx,
    input int           rst_idx
  );
    int         idx = 0;
    int         cyc = 0;
    int         ovr_cnt = 0;
    int         hold_err = 0;
    int         busy_err = 0;
    int         done_err = 0;
    bit         prev_stall = 1'b0;
    bit         ovr_sent = 1'b0;
    bit         aborted = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] exp;
    @(negedge clk);
    hh = d;
    h_done = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    h_done = 1'b0;
    cyc = 1;
    while (idx < 42 && cyc < 2000) begin
      if (overrun) ovr_cnt++;
      if (!busy) busy_err++;
      if (spart_done) done_err++;
      if (prev_stall && tx_data !== prev_data) hold_err++;
      h_done = 1'b0;
      if (rst_idx >= 0 && idx == rst_idx) begin
        aborted = 1'b1;
        break;
      end
      if (ovr_idx >= 0 && idx == ovr_idx && !ovr_sent) begin
        h_done = 1'b1;
        hh = '1;
        ovr_sent = 1'b1;
      end
      tx_ready = bp ? ($urandom_range(2) == 0) : 1'b1;
      if (tx_valid && tx_ready) begin
        if (idx < 40) exp = hex[idx];
        else exp = (idx == 40) ? 8'h0D : 8'h0A;
        check($sformatf("%s sym%0d", name, idx),
              32'(tx_data), 32'(exp));
        idx++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data = tx_data;
      @(negedge clk);
      cyc++;
    end
    h_done = 1'b0;
    if (aborted) begin
      rst_n = 1'b0;
      #1;
      check({name, " rst valid"}, 32'(tx_valid), 0);
      check({name, " rst busy"}, 32'(busy), 0);
      done_err = 0;
      repeat (3) begin
        @(negedge clk);
        if (spart_done) done_err++;
      end
      rst_n = 1'b1;
      repeat (50) begin
        @(negedge clk);
        if (spart_done || tx_valid) done_err++;
      end
      check({name, " no done"}, 32'(done_err), 0);
    end else begin
      check({name, " count"}, 32'(idx), 42);
      check({name, " done"}, 32'(spart_done), 1);
      check({name, " done valid"}, 32'(tx_valid), 0);
      if (!bp) check({name, " latency"}, 32'(cyc), 43);
      check({name, " hold"}, 32'(hold_err), 0);
      check({name, " busy"}, 32'(busy_err), 0);
      check({name, " early done"}, 32'(done_err), 0);
      check({name, " overrun"}, 32'(ovr_cnt),
            (ovr_idx >= 0) ? 32'd1 : 32'd0);
      @(negedge clk);
      check({name, " done pulse"}, 32'(spart_done), 0);
      check({name, " idle"}, 32'(busy), 0);
    end
  endtask

  task automatic stream_raw(
    input string        name,
    input logic [159:0] d
  );
    int         idx = 0;
    int         cyc = 0;
    logic [7:0] exp;
    @(negedge clk);
    hh_r = d;
    h_done_r = 1'b1;
    tx_ready_r = 1'b1;
    @(negedge clk);
    h_done_r = 1'b0;
    cyc = 1;
    while (idx < 20 && cyc < 200) begin
      if (tx_valid_r && tx_ready_r) begin
        exp = d[159 - 8 * idx -: 8];
        check($sformatf("%s byte%0d", name, idx),
              32'(tx_data_r), 32'(exp));
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    check({name, " count"}, 32'(idx), 20);
    check({name, " latency"}, 32'(cyc), 21);
    check({name, " done"}, 32'(spart_done_r), 1);
    check({name, " done valid"}, 32'(tx_valid_r), 0);
    @(negedge clk);
    check({name, " done pulse"}, 32'(spart_done_r), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset tx_data", 32'(tx_data), 0);
    check("reset tx_valid", 32'(tx_valid), 0);
    check("reset busy", 32'(busy), 0);
    check("reset spart_done", 32'(spart_done), 0);
    check("reset overrun", 32'(overrun), 0);
    check("reset raw valid", 32'(tx_valid_r), 0);
    rst_n = 1'b1;
    @(negedge clk);
    stream_hex("abc", ABC, ABC_S, 1'b0, -1, -1);
    stream_raw("raw", ABC);
    stream_hex("bp", ABC, ABC_S, 1'b1, -1, -1);
    stream_hex("ovr", ABC, ABC_S, 1'b0, 5, -1);
    stream_hex("rst", ABC, ABC_S, 1'b0, -1, 10);
    stream_hex("zero", '0, ZERO_S, 1'b0, -1, -1);
    stream_hex("bnd", BND, BND_S, 1'b0, -1, -1);
    $display("[TB] %0d tests run, %0d failed",
             tests_run, tests_failed);
    $finish;
  end

endmodule
